fir_out_adapter: RTL and testbench



---
 rtl/fir_pkg.sv | 67 ++++++
 rtl/fir_out_fifo.sv | 70 +++++++
 rtl/fir_out_adapter.sv | 126 ++++++++++++
 tb/tb_fir_out_adapter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output adapter: the status bundle, the
// sat_cnt width, and the scaling/clipping helpers used by the datapath.
package fir_pkg;

    localparam int SAT_CNT_W = 16;
    localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

    typedef struct packed {
        logic                 ovf;
        logic                 sat;
        logic [SAT_CNT_W-1:0] sat_cnt;
    } fir_status_t;

    // Arithmetic shift right by drop bits. With round_en set, the result is
    // rounded half-to-even; otherwise it is the floor (round toward -inf).
    function automatic logic signed [63:0] fir_scale(
        input logic signed [63:0] x,
        input int                 drop,
        input logic               round_en
    );
        logic signed [63:0] q;
        logic [63:0]        mask;
        logic [63:0]        frac;
        logic [63:0]        half;
        q    = x >>> drop;
        mask = (64'd1 << drop) - 64'd1;
        frac = x & mask;
        half = 64'd1 << (drop - 1);
        if (round_en && ((frac > half) || ((frac == half) && q[0]))) begin
            q = q + 64'sd1;
        end
        return q;
    endfunction

    // Clamp x into the signed range of a w-bit two's complement number.
    function automatic logic signed [63:0] fir_saturate(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // True when fir_saturate would change x.
    function automatic logic fir_clipped(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO with registered pointers and a count of log2(DEPTH)+1
// bits for full/empty. The head word is presented combinationally so a
// write becomes visible on the cycle after it lands; the output reads as
// zero while the FIFO is empty. A write on a full FIFO is accepted only
// when a read happens on the same edge, otherwise it is dropped and
// flagged on drop_o.
module fir_out_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    // Handshake decode and next pointer/count values.
    always_comb begin
        empty_o  = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_rd    = rd_en_i & ~empty_o;
        do_wr    = wr_en_i & (~full | do_rd);
        drop_o   = wr_en_i & ~do_wr;
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        rd_data_o = empty_o ? '0 : mem[rd_ptr_q];
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates the output.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fir_out_adapter.sv
// FIR output adapter: scales a wide filter sample down by DROP_LSB bits,
// clips it to OUT_WIDTH and queues it in a small FIFO with a valid/ready
// output. Sticky ovf/sat flags and a saturating clip counter report drops
// and clipping.
// Define FIR_OUT_ADAPTER_ROUND_EN for convergent (half-to-even) rounding;
// by default the scaling truncates toward -inf. Latency is the same.
module fir_out_adapter
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = 26,
    parameter int DROP_LSB   = 10,
    parameter int OUT_WIDTH  = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_out,
    input  logic [IN_WIDTH-1:0]  dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    input  logic                 clr_flags,
    output logic                 ovf,
    output logic                 sat,
    output logic [15:0]          sat_cnt
);

    // One extra bit above the shifted width so a round-up never wraps.
    localparam int S1W = IN_WIDTH - DROP_LSB + 1;

`ifdef FIR_OUT_ADAPTER_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic                        s1_valid_q;
    logic signed [S1W-1:0]       s1_data_q, s1_data_d;
    logic                        s2_valid_q;
    logic signed [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                        s2_clip_d;
    logic                        clip_evt;
    fir_status_t                 status_q, status_d;
    logic                        fifo_rd;
    logic                        fifo_empty;
    logic                        fifo_drop;
    logic [OUT_WIDTH-1:0]        fifo_rd_data;

    // Datapath next values: scale/round for stage 1, clip for stage 2.
    always_comb begin
        s1_data_d = S1W'(fir_scale(64'($signed(dout)), DROP_LSB, ROUND_EN));
        s2_data_d = OUT_WIDTH'(fir_saturate(64'(s1_data_q), OUT_WIDTH));
        s2_clip_d = fir_clipped(64'(s1_data_q), OUT_WIDTH);
    end

    // Two-stage pipeline; data registers only load behind a valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= valid_out;
            if (valid_out) begin
                s1_data_q <= s1_data_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
            end
        end
    end

    // Sticky status: clear first, so a set event on the same edge wins.
    always_comb begin
        clip_evt = s1_valid_q & s2_clip_d;
        status_d = status_q;
        if (clr_flags) begin
            status_d.ovf     = 1'b0;
            status_d.sat     = 1'b0;
            status_d.sat_cnt = '0;
        end
        if (fifo_drop) begin
            status_d.ovf = 1'b1;
        end
        if (clip_evt) begin
            status_d.sat = 1'b1;
            if (status_d.sat_cnt != SAT_CNT_MAX) begin
                status_d.sat_cnt = status_d.sat_cnt + SAT_CNT_W'(1);
            end
        end
    end

    // Status register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign fifo_rd = m_valid & m_ready;

    fir_out_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (s2_valid_q),
        .wr_data_i (s2_data_q),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rd_data),
        .empty_o   (fifo_empty),
        .drop_o    (fifo_drop)
    );

    assign m_valid = ~fifo_empty;
    assign m_data  = fifo_rd_data;
    assign ovf     = status_q.ovf;
    assign sat     = status_q.sat;
    assign sat_cnt = status_q.sat_cnt;

endmodule

// File: tb/tb_fir_out_adapter.sv
// Bench for fir_out_adapter: table of rounding vectors plus hand-written
// sequences for saturation, flag clearing, overflow, full read/write,
// latency and mid-stream reset. Output data is checked by a scoreboard
// queue filled as samples are driven.
module tb_fir_out_adapter;

`ifdef FIR_OUT_ADAPTER_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_out;
    logic [25:0] dout;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_data;
    logic        clr_flags;
    logic        ovf;
    logic        sat;
    logic [15:0] sat_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;

    typedef struct {
        logic [25:0]        din;
        logic signed [11:0] rnd;
        logic signed [11:0] trc;
    } vec_t;
    vec_t vecs[10];

    fir_out_adapter #(
        .IN_WIDTH   (26),
        .DROP_LSB   (10),
        .OUT_WIDTH  (12),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_out (valid_out),
        .dout      (dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .clr_flags (clr_flags),
        .ovf       (ovf),
        .sat       (sat),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [25:0] d, input logic [11:0] e, input bit keep);
        valid_out = 1'b1;
        dout      = d;
        if (keep) exp_q.push_back(e);
        tick();
        valid_out = 1'b0;
        dout      = 26'($urandom);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Pulse valid_out once into an empty FIFO and watch m_valid cycle by cycle.
    task automatic lat_check(input logic [25:0] d, input logic [11:0] e, input string name);
        valid_out = 1'b1;
        dout      = d;
        exp_q.push_back(e);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("%s_k+%0d", name, c), 32'(m_valid), 32'(c == 3));
            @(posedge clk);
            #1;
            valid_out = 1'b0;
        end
    endtask

    // Scoreboard: every accepted output word must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got data 0x%0h, want no output", m_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop", 32'(m_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{26'h600,        12'sd2,     12'sd1};
        vecs[1] = '{26'hA00,        12'sd2,     12'sd2};
        vecs[2] = '{26'hE00,        12'sd4,     12'sd3};
        vecs[3] = '{-26'sd1536,     -12'sd2,    -12'sd2};
        vecs[4] = '{26'h3FF,        12'sd1,     12'sd0};
        vecs[5] = '{26'h3FFFFFF,    12'sd0,     -12'sd1};
        vecs[6] = '{26'h200,        12'sd0,     12'sd0};
        vecs[7] = '{26'h400,        12'sd1,     12'sd1};
        vecs[8] = '{26'd2096128,    12'sd2047,  12'sd2047};
        vecs[9] = '{-26'sd2097152,  -12'sd2048, -12'sd2048};

        rst = 1'b1; valid_out = 1'b0; dout = '0; m_ready = 1'b0; clr_flags = 1'b0;
        repeat (3) tick();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);
        check("rst_ovf",     32'(ovf),     32'd0);
        check("rst_sat",     32'(sat),     32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Rounding/truncation table, with gaps between some samples.
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].din, RND ? vecs[i].rnd : vecs[i].trc, 1'b1);
            if (i % 3 == 2) repeat (2) tick();
        end
        wait_drain(20, "round_drain");
        check("round_sat",     32'(sat),     32'd0);
        check("round_sat_cnt", 32'(sat_cnt), 32'd0);

        // Saturation both directions.
        send(26'(3000 * 1024), 12'h7FF, 1'b1);
        send(26'(-3000 * 1024), 12'h800, 1'b1);
        wait_drain(20, "sat_drain");
        check("sat_flag", 32'(sat),     32'd1);
        check("sat_cnt2", 32'(sat_cnt), 32'd2);

        // Clear on the same edge as a clip: sat stays set, count restarts at 1.
        send(26'(3000 * 1024), 12'h7FF, 1'b1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        wait_drain(20, "clrclip_drain");
        check("clrclip_sat",     32'(sat),     32'd1);
        check("clrclip_sat_cnt", 32'(sat_cnt), 32'd1);

        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_sat",     32'(sat),     32'd0);
        check("clr_sat_cnt", 32'(sat_cnt), 32'd0);

        // Overflow: 10 samples into a stalled 8-deep FIFO.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(26'((i + 1) * 1024), 12'(i + 1), i < 8);
        end
        repeat (4) tick();
        check("ovf_set",    32'(ovf),     32'd1);
        check("ovf_valid",  32'(m_valid), 32'd1);
        check("ovf_head",   32'(m_data),  32'd1);
        tick();
        check("stall_hold", 32'(m_data),  32'd1);
        m_ready = 1'b1;
        wait_drain(30, "ovf_drain");
        check("ovf_empty", 32'(m_valid), 32'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);

        // Full FIFO with simultaneous read and write on every edge.
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) m_ready = 1'b1;
            send(26'((100 + i) * 1024), 12'(100 + i), 1'b1);
        end
        wait_drain(40, "fullrw_drain");
        check("fullrw_ovf", 32'(ovf), 32'd0);

        // Latency from a single pulse into an empty FIFO, then idle gap.
        tick();
        lat_check(26'(5 * 1024), 12'd5, "lat");
        repeat (5) tick();
        wait_drain(10, "lat_drain");

        // Reset with five samples buffered and two more in flight.
        m_ready = 1'b0;
        send(26'(3000 * 1024), 12'h7FF, 1'b1);
        for (int i = 1; i < 5; i++) send(26'(i * 1024), 12'(i), 1'b1);
        repeat (3) tick();
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        check("pre_rst_sat",   32'(sat),     32'd1);
        send(26'(6 * 1024), 12'd6, 1'b0);
        send(26'(7 * 1024), 12'd7, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_data",  32'(m_data),  32'd0);
        check("midrst_ovf",     32'(ovf),     32'd0);
        check("midrst_sat",     32'(sat),     32'd0);
        check("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        lat_check(26'(9 * 1024), 12'd9, "postrst");
        repeat (5) tick();
        wait_drain(10, "postrst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
